// File: rtl/sclk_burst_ctrl.sv
// sclk_burst_ctrl: sequencer for the 8-bit sclk prescaler.
//
// This block takes a burst command made of a divider value and a period count.
// It loads the divider into the prescaler, enables the prescaler, and counts
// completed sclk periods on the falling-edge strobe. It then disables the
// prescaler and pulses o_done. If i_abort is seen first, it pulses o_aborted.
//
// Ports
//   i_sysclk, i_sysrst   clock, synchronous active-low reset
//   i_start, i_div, i_len  burst request; accepted only while o_ready=1
//   i_abort              terminate the burst in progress (LOAD or RUN)
//   i_ps_sclk_rise/fall  prescaler edge strobes
//   o_ps_en, o_ps_ld, o_ps_ld_data  prescaler controls (sole driver)
//   o_ready, o_busy      IDLE / (LOAD or RUN) status
//   o_done, o_aborted    one-cycle completion pulses
//   o_period_cnt         completed periods of the current or last burst
//
// Optional feature macro: SCLK_BURST_CTRL_EDGE_CHK_EN
//   Defining it adds the input i_err_clr and the output o_err. o_err is a
//   sticky flag for malformed strobe sequences. It never affects the FSM.

module sclk_burst_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_div,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_ps_sclk_rise,
    input  logic             i_ps_sclk_fall,
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
    input  logic             i_err_clr,
    output logic             o_err,
`endif
    output logic             o_ps_en,
    output logic             o_ps_ld,
    output logic [DIV_W-1:0] o_ps_ld_data,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [LEN_W-1:0] o_period_cnt
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StAbort} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   ld_data_q, ld_data_d;
    logic               en_q, en_d;
    logic               ld_q, ld_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    ld_data_d = i_div;
                    len_d     = i_len;
                    cnt_d     = '0;
                    // A zero-length burst completes without enabling the prescaler.
                    state_d   = (i_len != '0) ? StLoad : StDone;
                end
            end
            StLoad: begin
                state_d = i_abort ? StAbort : StRun;
            end
            StRun: begin
                // Abort takes priority over the final fall, so that fall is not counted.
                if (i_abort) begin
                    state_d = StAbort;
                end else if (i_ps_sclk_fall) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The outputs are registered decodes of the next state.
        en_d      = (state_d == StRun);
        ld_d      = (state_d == StLoad);
        ready_d   = (state_d == StIdle);
        busy_d    = (state_d == StLoad) || (state_d == StRun);
        done_d    = (state_d == StDone);
        aborted_d = (state_d == StAbort);
    end

    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            ld_data_q <= '0;
            en_q      <= 1'b0;
            ld_q      <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            en_q      <= en_d;
            ld_q      <= ld_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_ps_en      = en_q;
    assign o_ps_ld      = ld_q;
    assign o_ps_ld_data = ld_data_q;
    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_aborted    = aborted_q;
    assign o_period_cnt = cnt_q;

`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
    logic err_q, err_d;
    logic last_fall_q, last_fall_d;
    logic err_set;

    always_comb begin
        // Error sources: rise and fall together, two falls with no rise between
        // them, or any strobe while the prescaler is disabled.
        err_set = (i_ps_sclk_rise && i_ps_sclk_fall) ||
                  (i_ps_sclk_fall && last_fall_q) ||
                  ((i_ps_sclk_rise || i_ps_sclk_fall) && !en_q);
        last_fall_d = last_fall_q;
        if (i_ps_sclk_rise) last_fall_d = 1'b0;
        if (i_ps_sclk_fall) last_fall_d = 1'b1;
        err_d = err_q;
        if (i_err_clr) err_d = 1'b0;
        if (err_set)   err_d = 1'b1;
    end

    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst) begin
            err_q       <= 1'b0;
            last_fall_q <= 1'b0;
        end else begin
            err_q       <= err_d;
            last_fall_q <= last_fall_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_rise;
    assign unused_rise = i_ps_sclk_rise;
`endif

endmodule

// File: tb/tb_sclk_burst_ctrl.sv
module tb_sclk_burst_ctrl;

    localparam int DIV_W = 8;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DIV_W-1:0] div;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             rise;
    logic             fall;
    logic             ps_en, ps_ld, ready, busy, done, aborted;
    logic [DIV_W-1:0] ld_data;
    logic [LEN_W-1:0] period_cnt;
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
    logic             err_clr;
    logic             err;
`endif

    int tests = 0;
    int fails = 0;

    sclk_burst_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
        .i_sysclk       (clk),
        .i_sysrst       (rst_n),
        .i_start        (start),
        .i_div          (div),
        .i_len          (len),
        .i_abort        (abort),
        .i_ps_sclk_rise (rise),
        .i_ps_sclk_fall (fall),
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
        .i_err_clr      (err_clr),
        .o_err          (err),
`endif
        .o_ps_en        (ps_en),
        .o_ps_ld        (ps_ld),
        .o_ps_ld_data   (ld_data),
        .o_ready        (ready),
        .o_busy         (busy),
        .o_done         (done),
        .o_aborted      (aborted),
        .o_period_cnt   (period_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        start = 1'b0; div = '0; len = '0; abort = 1'b0; rise = 1'b0; fall = 1'b0;
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({ps_en, ps_ld, ready, busy, done, aborted} !== 6'b001000 ||
            ld_data !== '0 || period_cnt !== '0) begin
            fails++;
            $display("FAIL reset: en/ld/rdy/busy/done/abt=%b ld_data=%0d cnt=%0d, want 001000 0 0",
                     {ps_en, ps_ld, ready, busy, done, aborted}, ld_data, period_cnt);
        end
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err: o_err=%b want 0", err);
        end
`endif
    endtask

    // Runs one burst. Cycle 0 is the cycle in which i_start is driven. The prescaler
    // strobes come from the ideal period formula. ab_cyc=0 means no abort. In every
    // later cycle all outputs are compared with the timeline the reference predicts.
    task automatic run_burst(input string name, input int d, input int n, input int ab_cyc,
                             input bit busy_start);
        int  per, full_end, last, exp_cnt, cutoff;
        bit  is_ab;
        logic [5:0] exp_flags, obs_flags;
        per      = 2 * (d + 1);
        full_end = (n == 0) ? 1 : 2 + n * per;
        is_ab    = (n > 0) && (ab_cyc != 0);
        last     = is_ab ? ab_cyc + 1 : full_end;
        for (int t = 0; t <= last + 1; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                cutoff  = (is_ab && ab_cyc < t) ? ab_cyc : t;
                exp_cnt = 0;
                for (int k = 1; k <= n; k++)
                    if (1 + k * per < cutoff) exp_cnt++;
                exp_flags = {(n > 0 && t >= 2 && t <= last - 1),  // en
                             (n > 0 && t == 1),                   // ld
                             (t >= last + 1),                     // ready
                             (n > 0 && t <= last - 1),            // busy
                             (t == last && !is_ab),               // done
                             (t == last && is_ab)};               // aborted
                obs_flags = {ps_en, ps_ld, ready, busy, done, aborted};
                tests++;
                if (obs_flags !== exp_flags || period_cnt !== LEN_W'(exp_cnt) ||
                    ld_data !== DIV_W'(d)) begin
                    fails++;
                    $display("FAIL %s cyc%0d: en/ld/rdy/busy/done/abt=%b cnt=%0d data=%0d, want %b %0d %0d",
                             name, t, obs_flags, period_cnt, ld_data, exp_flags, exp_cnt, d);
                end
            end
            // Drive this cycle's inputs.
            start = (t == 0) || (busy_start && t >= 1 && t <= last);
            div   = (t == 0) ? DIV_W'(d) : DIV_W'($urandom);
            len   = (t == 0) ? LEN_W'(n) : LEN_W'($urandom_range(1, 9));
            abort = is_ab && (t == ab_cyc);
            rise  = (t >= 2 && t <= last - 1 && (t - 1) % per == d + 1);
            fall  = (t >= 2 && t <= last - 1 && (t - 1) % per == 0);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        run_burst("basic_d2_n3", 2, 3, 0, 1'b0);
    endtask

    task automatic test_zero_len();
        run_burst("zero_len", 5, 0, 0, 1'b0);
    endtask

    task automatic test_div0();
        run_burst("div0_n4", 0, 4, 0, 1'b0);
    endtask

    task automatic test_abort();
        // For d=1 the falls are at cycles 5 and 9, so the abort is driven in cycle 10.
        run_burst("abort_after2", 1, 5, 10, 1'b0);
        run_burst("abort_in_load", 3, 2, 1, 1'b0);
    endtask

    task automatic test_abort_final_fall();
        // The only fall is at cycle 3, and the abort is driven in that same cycle.
        run_burst("abort_final", 0, 1, 3, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_burst("start_busy", 2, 2, 0, 1'b1);
    endtask

    task automatic test_reset_in_run();
        run_burst("pre_rst", 1, 1, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; div = 8'd1; len = 16'd5;
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
        tests++;
        if (ps_en !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_run_pre: en=%b busy=%b want 1 1", ps_en, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({ps_en, ps_ld, ready, busy, done, aborted} !== 6'b001000 ||
            ld_data !== '0 || period_cnt !== '0) begin
            fails++;
            $display("FAIL rst_run: flags=%b data=%0d cnt=%0d want 001000 0 0",
                     {ps_en, ps_ld, ready, busy, done, aborted}, ld_data, period_cnt);
        end
    endtask

    task automatic test_random();
        int d, n, ab, full_end;
        for (int i = 0; i < 24; i++) begin
            d  = $urandom_range(0, 3);
            n  = $urandom_range(0, 6);
            ab = 0;
            full_end = 2 + n * 2 * (d + 1);
            if (n > 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, full_end - 1);
            run_burst($sformatf("rand%0d", i), d, n, ab, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
    task automatic test_edge_chk();
        @(negedge clk);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clean: o_err=%b want 0", err);
        end
        rise = 1'b1; fall = 1'b1;
        @(negedge clk);
        rise = 1'b0; fall = 1'b0;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_set: o_err=%b want 1", err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: o_err=%b want 1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clr: o_err=%b want 0", err);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_zero_len();
        test_div0();
        test_abort();
        test_abort_final_fall();
        test_start_while_busy();
        test_reset_in_run();
        test_random();
`ifdef SCLK_BURST_CTRL_EDGE_CHK_EN
        test_edge_chk();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
